// File: rtl/midi_tx_sched.sv
// midi_tx_sched: round-robin scheduler sharing one MIDI byte transmitter
// among NUM_REQ message sources. Latches one 1..3 byte message per grant
// and streams it over a valid/ready byte interface without interleaving.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running-status elision
// of a repeated channel-voice status byte).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for any req; picks next slot from rr_ptr upward
// S_GRANT | grant pulse out; message validated, rr_ptr advanced
// S_SEND  | bytes of the latched message handed to the serializer
module midi_tx_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*24-1:0]   i_req_msg,
  input  logic [NUM_REQ*2-1:0]    i_req_len,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic                    o_drop,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SEND} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_sel;
  logic [23:0]     r_msg;
  logic [1:0]      r_len;
  logic [1:0]      r_idx;

  logic [PW-1:0]   w_sel;
  logic            w_found;
  logic [23:0]     w_msg_arr [NUM_REQ];
  logic [1:0]      w_len_arr [NUM_REQ];
  logic [23:0]     w_msg;
  logic [1:0]      w_len;
  logic            w_illegal;
  logic [PW-1:0]   w_next_ptr;
  logic [1:0]      w_start;

  function automatic logic [7:0] byte_at(input logic [23:0] m, input logic [1:0] i);
    case (i)
      2'd0:    byte_at = m[7:0];
      2'd1:    byte_at = m[15:8];
      default: byte_at = m[23:16];
    endcase
  endfunction

  // Unflatten per-slot message/length buses.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_msg_arr[k] = i_req_msg[24*k +: 24];
      w_len_arr[k] = i_req_len[2*k +: 2];
    end
  end

  // First pending slot scanning upward from rr_ptr with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[PW'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_msg      = w_msg_arr[w_sel];
  assign w_len      = w_len_arr[w_sel];
  // Zero length or a non-status first byte cannot be sent as a message.
  assign w_illegal  = (w_len == 2'd0) || !w_msg[7];
  assign w_next_ptr = (r_sel == PW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;
  logic       w_chan_voice;

  assign w_chan_voice = r_msg[7] && (r_msg[7:4] != 4'hF);
  assign w_start = (w_chan_voice && (r_msg[7:0] == r_last_status) && (r_len >= 2'd2))
                   ? 2'd1 : 2'd0;

  // Track the last status byte actually put on the wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_status <= 8'h00;
    end else if (r_state == S_SEND && i_tx_ready && r_idx == 2'd0) begin
      if (w_chan_voice)
        r_last_status <= r_msg[7:0];
      else if (r_msg[7:3] == 5'b11110)
        r_last_status <= 8'h00;
    end
  end
`else
  assign w_start = 2'd0;
`endif

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_msg      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      o_grant    <= '0;
      o_drop     <= 1'b0;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_grant <= '0;
      o_drop  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_sel;
            r_msg   <= w_msg;
            r_len   <= w_len;
            o_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            o_drop  <= w_illegal;
            o_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_rr_ptr <= w_next_ptr;
          if (o_drop) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx      <= w_start;
            o_tx_data  <= byte_at(r_msg, w_start);
            o_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_tx_ready) begin
            if (r_idx == r_len - 2'd1) begin
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= r_idx + 2'd1;
              o_tx_data <= byte_at(r_msg, r_idx + 2'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/midi_tx_sched.md
# midi_tx_sched

Round-robin scheduler that shares the single MIDI byte transmitter among `NUM_REQ` message sources (button slots, MIDI-thru, learn-mode echo). It latches one complete 1–3 byte MIDI message per grant and feeds its bytes, in order and without interleaving, to the UART serializer over a valid/ready byte interface. It sits between the button/learn logic and the 31250-baud serializer, in the `clk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester message-pending flag; held until `grant` bit seen.
- `req_msg`  in  NUM_REQ*24  flattened messages; slot i = bits [24i+23:24i]; byte0 (status) in [7:0], byte1 [15:8], byte2 [23:16].
- `req_len`  in  NUM_REQ*2  flattened byte counts; slot i = [2i+1:2i]; legal 1..3.
- `grant`  out  NUM_REQ  one-cycle one-hot pulse: message of slot i latched.
- `drop`  out  1  one-cycle pulse: granted message rejected (illegal).
- `tx_data`  out  8  byte to serializer.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  serializer accepts byte when `tx_valid && tx_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, GRANT, SEND.
- IDLE: if `req` != 0, select first set bit scanning from `rr_ptr` upward with wrap; latch its message/length; go GRANT. Else stay.
- GRANT (1 cycle): `grant[sel]`=1. Validate: length 0, or byte0[7]==0 -> `drop`=1, back to IDLE, nothing sent. Otherwise `idx`<=first byte to send, go SEND. `rr_ptr` <= sel+1 mod NUM_REQ in both cases.
- SEND: `tx_valid`=1, `tx_data`=latched byte[`idx`]. On handshake, `idx`+1; after byte `len`-1 accepted, go IDLE. `tx_data` stable while `tx_valid && !tx_ready`.
- Bytes of one message never interleave with another; `req` changes during GRANT/SEND ignored until IDLE.
- Simultaneous requests: round-robin from `rr_ptr`; slot held continuously is served again only after all other pending slots.
- Data bytes not checked for MSB; sent verbatim.
- Reset value of all outputs 0; `rr_ptr`=0; state IDLE; latched message 0; running-status register cleared.
- Reset mid-message: transfer aborted immediately, `tx_valid` drops asynchronously; no resumption.

## Timing
- `req` sampled in IDLE at edge N -> `grant` high cycle N+1 -> `tx_valid` high cycle N+2.
- One byte per cycle max when `tx_ready` constantly high: 3-byte message occupies cycles N+2..N+4; IDLE at N+5, next grant earliest N+6.
- Minimum message turnaround: len+3 cycles.
- All outputs registered; no combinational path `tx_ready` -> `tx_valid`/`tx_data`.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: register `last_status` (8 b, reset 0). In GRANT, channel-voice status (0x80–0xEF) equal to `last_status` with len>=2 -> status byte skipped, `idx` starts at 1. Sent channel-voice status updates `last_status`; sent 0xF0–0xF7 clears it; 0xF8–0xFF (realtime) leaves it unchanged. Drop does not change it.
- Undefined: `last_status` absent; every byte of every message sent.

## Test plan
- Single req: slot 0 msg {0xB0,0x2E,0x7F}, len 3, `tx_ready`=1 -> `grant`=0001 at N+1; bytes 0xB0,0x2E,0x7F on N+2..N+4; `busy` low N+5.
- Contention: slots 0,2,3 held high, len 1, 0xF8 -> grant order 0,2,3,0,2,3; no byte interleaving.
- Backpressure: `tx_ready` low 5 cycles during byte1 -> `tx_data`=0x2E, `tx_valid`=1 stable; resumes with 0x7F after accept.
- Illegal: slot 1 len 0, then slot 1 {0x2E,...} len 3 -> two `drop` pulses, `tx_valid` never high, `rr_ptr` advances.
- Running status (macro on): two msgs {0x90,0x3C,0x40} -> 5 bytes: 0x90,0x3C,0x40,0x3C,0x40; insert 0xF8 between -> still skipped; insert 0xF6 -> 0x90 resent. Macro off -> 6 bytes.
- Reset after byte 1 of 3 -> `tx_valid`,`busy`,`grant` 0 immediately; after release, pending req re-granted from slot 0.
